// File: rtl/mysystem_mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: widths, owner tag type
// and a one-hot to index helper.
package mysystem_mul_arb_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned RES_W       = 2 * DATA_W;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned MAX_TAG_W   = $clog2(MAX_REQ);
    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned TAG_W       = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef logic [TAG_W-1:0] tag_t;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [MAX_TAG_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_TAG_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_TAG_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mysystem_mul_share_arb_arbiter.sv
// Round-robin arbiter: grant is the first request above the last winner,
// wrapping; the pointer moves only when the grant is actually taken.
module mysystem_rr_arbiter
    import mysystem_mul_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_c = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                grant_c[cand] = 1'b1;
                found         = 1'b1;
            end
        end
        grant_idx_c = IDX_W'(onehot_to_idx(MAX_REQ'(grant_c)));
        ptr_d       = advance ? grant_idx_c : ptr_q;
    end

    // Reset to the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mysystem_mul_share_arb.sv
// Shares one 2-stage pipelined multiplier cell between NUM_REQ requesters and
// routes each product back to the requester that issued it.
module mysystem_mul_share_arb
    import mysystem_mul_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_src1,
    input  logic [NUM_REQ*DATA_W-1:0] req_src2,
    input  logic [NUM_REQ-1:0]        req_src1_sgn,
    input  logic [NUM_REQ-1:0]        req_src2_sgn,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [RES_W-1:0]          rsp_result,
    output logic [DATA_W-1:0]         mul_src1,
    output logic [DATA_W-1:0]         mul_src2,
    output logic                      mul_src1_sgn,
    output logic                      mul_src2_sgn,
    output logic                      mul_in_en,
    output logic                      mul_out_en,
    input  logic [RES_W-1:0]          mul_result
);

    logic             s1_v_q,   s1_v_d;
    logic             s2_v_q,   s2_v_d;
    logic [IDX_W-1:0] s1_tag_q, s1_tag_d;
    logic [IDX_W-1:0] s2_tag_q, s2_tag_d;

    logic [NUM_REQ-1:0] req_act;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               rsp_fire;
    logic               issue;

    // Requests are ignored while reset is held so nothing is granted or driven.
    assign req_act = req_valid & {NUM_REQ{reset_n}};

    mysystem_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req_act),
        .advance     (issue),
        .grant_c     (grant),
        .grant_idx_c (grant_idx)
    );

    always_comb begin
        rsp_fire   = s2_v_q & rsp_ready[s2_tag_q];
        mul_out_en = reset_n & (~s2_v_q | rsp_fire);
        mul_in_en  = reset_n & (~s1_v_q | mul_out_en);
        req_ready  = grant & {NUM_REQ{mul_in_en}};
        issue      = |req_ready;

        mul_src1     = '0;
        mul_src2     = '0;
        mul_src1_sgn = 1'b0;
        mul_src2_sgn = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_src1     = req_src1[i*DATA_W +: DATA_W];
                mul_src2     = req_src2[i*DATA_W +: DATA_W];
                mul_src1_sgn = req_src1_sgn[i];
                mul_src2_sgn = req_src2_sgn[i];
            end
        end

        rsp_valid = '0;
        if (s2_v_q) begin
            rsp_valid[s2_tag_q] = 1'b1;
        end
        rsp_result = mul_result;

        // Tags shadow the cell registers, so they move on the same enables.
        s1_v_d   = s1_v_q;
        s1_tag_d = s1_tag_q;
        s2_v_d   = s2_v_q;
        s2_tag_d = s2_tag_q;
        if (mul_out_en) begin
            s2_v_d   = s1_v_q;
            s2_tag_d = s1_tag_q;
        end
        if (mul_in_en) begin
            s1_v_d   = issue;
            s1_tag_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q   <= 1'b0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_tag_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_tag_q <= s2_tag_d;
        end
    end

endmodule
